mio_bus_arbiter: RTL and testbench

Shares the single RAM/MIO bus between the multicycle CPU controller's memory port and a debug/loader master. Serialises one access at a time, inserts a fixed number of RAM wait states, and returns a one-cycle completion strobe. The CPU strobe is `MIO_ready`, which the controller samples in IF. The block sits between the CPU datapath (`IorD`-muxed address, `MemRead`/`MemWrite`, `RAMCtrl`) and the RAM.

---
 rtl/mio_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - RAM/MIO bus arbiter between CPU memory port and debug master
// Optional round-robin arbitration: define MIO_RR_ARB_EN.
module mio_bus_arbiter #(
    parameter int unsigned RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_ramctrl,
    output logic [31:0] cpu_rdata,
    output logic        MIO_ready,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_ctrl,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    // The debug master has no width port; its accesses always use code 0.
    localparam logic [2:0] DBG_CTRL = 3'b000;
    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DBG  = 1'b1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_lat_cnt;
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dbg_rdata;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_ctrl;
    logic        r_mem_en;
    logic        r_mem_we;
    logic        r_mio_ready;
    logic        r_dbg_ack;
    logic        r_dbg_gnt;
    logic        w_grant;
    logic        w_pick;
    logic        w_owner_nxt;
    logic        w_we_nxt;

`ifdef MIO_RR_ARB_EN
    logic r_last_owner;

    always_comb begin
        if (cpu_req && dbg_req) begin
            w_pick = ~r_last_owner;
        end else begin
            w_pick = dbg_req ? OWN_DBG : OWN_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWN_CPU;
        end else if (w_grant) begin
            r_last_owner <= w_pick;
        end
    end
`else
    always_comb begin
        w_pick = cpu_req ? OWN_CPU : OWN_DBG;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_owner_nxt = r_owner;
        w_we_nxt    = r_we;
        case (r_state)
            S_IDLE: begin
                if (cpu_req || dbg_req) begin
                    w_grant     = 1'b1;
                    w_owner_nxt = w_pick;
                    w_we_nxt    = (w_pick == OWN_DBG) ? dbg_we : cpu_we;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_lat_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt   <= 4'd0;
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_ctrl      <= 3'd0;
            r_cpu_rdata <= 32'd0;
            r_dbg_rdata <= 32'd0;
        end else begin
            if (w_grant) begin
                r_owner   <= w_owner_nxt;
                r_we      <= w_we_nxt;
                r_addr    <= (w_owner_nxt == OWN_DBG) ? dbg_addr  : cpu_addr;
                r_wdata   <= (w_owner_nxt == OWN_DBG) ? dbg_wdata : cpu_wdata;
                r_ctrl    <= (w_owner_nxt == OWN_DBG) ? DBG_CTRL  : cpu_ramctrl;
                r_lat_cnt <= 4'(RAM_LAT - 1);
            end else if (r_state == S_ACCESS && r_lat_cnt != 4'd0) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (r_state == S_ACCESS && r_lat_cnt == 4'd0 && !r_we) begin
                if (r_owner == OWN_DBG) begin
                    r_dbg_rdata <= mem_rdata;
                end else begin
                    r_cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    // Strobes and enables are registered from the next state so no output is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mio_ready <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_dbg_gnt   <= 1'b0;
        end else begin
            r_mem_en    <= (w_state_nxt == S_ACCESS);
            r_mem_we    <= (w_state_nxt == S_ACCESS) && w_we_nxt;
            r_mio_ready <= (w_state_nxt == S_DONE) && (w_owner_nxt == OWN_CPU);
            r_dbg_ack   <= (w_state_nxt == S_DONE) && (w_owner_nxt == OWN_DBG);
            r_dbg_gnt   <= (w_state_nxt == S_ACCESS || w_state_nxt == S_DONE) &&
                           (w_owner_nxt == OWN_DBG);
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign MIO_ready = r_mio_ready;
    assign dbg_ack   = r_dbg_ack;
    assign dbg_gnt   = r_dbg_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_ctrl  = r_ctrl;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb/tb_mio_bus_arbiter.sv - directed self-checking bench for mio_bus_arbiter
module tb_mio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_ramctrl;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;

    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        MIO_ready, dbg_gnt, dbg_ack, mem_en, mem_we;
    logic [2:0]  mem_ctrl;

    logic [31:0] cpu_rdata1, dbg_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        MIO_ready1, dbg_gnt1, dbg_ack1, mem_en1, mem_we1;
    logic [2:0]  mem_ctrl1;

    int n_checks = 0;
    int n_errors = 0;

    int   t_lat, t_en, t_gnt, t_bad, t_other;
    logic t_after;
    logic tb_last;

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        if (a == 32'h40) return 32'h0000_00AA;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign mem_rdata  = ram_f(mem_addr);
    assign mem_rdata1 = ram_f(mem_addr1);

    always #5 clk = ~clk;

    mio_bus_arbiter #(.RAM_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ramctrl(cpu_ramctrl), .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
    );

    mio_bus_arbiter #(.RAM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ramctrl(cpu_ramctrl), .cpu_rdata(cpu_rdata1), .MIO_ready(MIO_ready1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt1), .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ctrl(mem_ctrl1), .mem_rdata(mem_rdata1)
    );

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task run_access(input logic dbg, input logic we, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [2:0] ctrl);
        t_lat = 0; t_en = 0; t_gnt = 0; t_bad = 0; t_other = 0;
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_ramctrl = ctrl;
        end
        for (int c = 1; c <= 20 && t_lat == 0; c++) begin
            @(negedge clk);
            if (mem_en) begin
                t_en++;
                if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata ||
                    (!dbg && mem_ctrl !== ctrl)) t_bad++;
            end
            if (dbg_gnt) t_gnt++;
            if (dbg ? MIO_ready : dbg_ack) t_other++;
            if (dbg ? dbg_ack : MIO_ready) t_lat = c;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        tb_last = dbg;
        @(negedge clk);
        t_after = dbg ? dbg_ack : MIO_ready;
    endtask

    logic [31:0] saved;
    logic        exp_win;
    logic        win;
    int          seen, last_c, gap1, gap2, n_pulse;

    initial begin
        rst_n = 1'b0; tb_last = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_ramctrl = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_ready", {29'd0, MIO_ready, dbg_ack, dbg_gnt}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_mem_en", {30'd0, mem_en, mem_we}, 32'd0);

        run_access(1'b0, 1'b0, 32'h10, 32'h0, 3'b000);
        check("rd_latency", t_lat, 32'd3);
        check("rd_en_cycles", t_en, 32'd2);
        check("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rd_stable", t_bad, 32'd0);
        check("rd_pulse_1cyc", {31'd0, t_after}, 32'd0);

        saved = cpu_rdata;
        run_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3'b010);
        check("wr_latency", t_lat, 32'd3);
        check("wr_en_cycles", t_en, 32'd2);
        check("wr_stable", t_bad, 32'd0);
        check("wr_rdata_kept", cpu_rdata, saved);

        run_access(1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
        check("dbg_latency", t_lat, 32'd3);
        check("dbg_gnt_cycles", t_gnt, 32'd3);
        check("dbg_rdata", dbg_rdata, 32'h0000_00AA);
        check("dbg_no_mio_ready", t_other, 32'd0);
        check("dbg_ack_1cyc", {31'd0, t_after}, 32'd0);
        check("dbg_gnt_released", {31'd0, dbg_gnt}, 32'd0);

        cpu_we = 0; cpu_addr = 32'h100; dbg_we = 0; dbg_addr = 32'h200;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
`ifdef MIO_RR_ARB_EN
            exp_win = ~tb_last;
`else
            exp_win = 1'b0;
`endif
            seen = 0; win = 1'b0;
            for (int c = 0; c < 20 && seen == 0; c++) begin
                @(negedge clk);
                if (MIO_ready || dbg_ack) begin
                    seen = 1;
                    win = dbg_ack;
                end
            end
            check($sformatf("tie%0d_seen", k), seen, 32'd1);
            check($sformatf("tie%0d_winner", k), {31'd0, win}, {31'd0, exp_win});
            if (seen == 1) tb_last = win;
        end
        check("tie_cpu_rdata", cpu_rdata, ram_f(32'h100));
        cpu_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (dbg_ack) seen = 1;
        end
        check("tie_dbg_served", seen, 32'd1);
        check("tie_dbg_rdata", dbg_rdata, ram_f(32'h200));
        dbg_req = 1'b0;
        tb_last = 1'b1;
        repeat (2) @(negedge clk);

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        repeat (2) @(negedge clk);
        check("abort_in_access", {31'd0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_en", {31'd0, mem_en}, 32'd0);
        check("abort_outputs", {29'd0, MIO_ready, dbg_ack, dbg_gnt}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        cpu_req = 1'b0;
        tb_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_pulse = 0;
        repeat (5) begin
            @(negedge clk);
            if (MIO_ready || mem_en) n_pulse++;
        end
        check("abort_no_strobe", n_pulse, 32'd0);
        run_access(1'b0, 1'b0, 32'h84, 32'h0, 3'b000);
        check("post_abort_latency", t_lat, 32'd3);
        check("post_abort_rdata", cpu_rdata, ram_f(32'h84));

        repeat (2) @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        seen = 0; last_c = 0; gap1 = 0; gap2 = 0;
        for (int c = 1; c <= 40 && seen < 3; c++) begin
            @(negedge clk);
            if (MIO_ready1) begin
                if (seen == 1) gap1 = c - last_c;
                if (seen == 2) gap2 = c - last_c;
                last_c = c;
                seen++;
            end
        end
        cpu_req = 1'b0;
        check("b2b_gap1", gap1, 32'd3);
        check("b2b_gap2", gap2, 32'd3);
        check("b2b_rdata", cpu_rdata1, ram_f(32'h300));
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
